// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a valid/ready dmem channel, aligns load data, registers writeback.
// Optional MEM_MISALIGN_TRAP_EN adds misalign_o and traps misaligned half/word accesses instead of issuing them.
module mem_stage #(
    parameter int unsigned RSP_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  mem_op_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [4:0]  rd_i,
    input  logic        wb_en_i,
    output logic        stall_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic [31:0] dmem_req_addr_o,
    output logic        dmem_req_we_o,
    output logic [3:0]  dmem_req_be_o,
    output logic [31:0] dmem_req_wdata_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rsp_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_en_o,
    output logic [31:0] wb_data_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        bus_err_o
);

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state;
    logic        is_store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [1:0]  lane;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic        wb_en;
    logic [31:0] count;

    logic        is_mem;
    logic        trap;
    logic        timeout;
    logic [3:0]  issue_be;
    logic [31:0] issue_wdata;
    logic [1:0]  issue_lane;

    // Pick the addressed lane of the response word and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lo,
                                            input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (sz)
            2'd0:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign is_mem  = valid_i && (mem_op_i == OP_LOAD || mem_op_i == OP_STORE);
    assign timeout = (RSP_TIMEOUT != 0) && (count == RSP_TIMEOUT - 1);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && ((mem_size_i == 2'd1 && addr_i[0]) ||
                             (mem_size_i[1] && addr_i[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Without the trap, low address bits below the access size are simply dropped.
    always_comb begin
        issue_be    = 4'b1111;
        issue_wdata = store_data_i;
        issue_lane  = 2'b00;
        case (mem_size_i)
            2'd0: begin
                issue_wdata = {4{store_data_i[7:0]}};
                issue_lane  = addr_i[1:0];
                if (mem_op_i == OP_STORE)
                    issue_be = 4'b0001 << addr_i[1:0];
            end
            2'd1: begin
                issue_wdata = {2{store_data_i[15:0]}};
                issue_lane  = {addr_i[1], 1'b0};
                if (mem_op_i == OP_STORE)
                    issue_be = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:    stall_o = is_mem && !trap;
            REQ:     stall_o = !(dmem_req_ready_i && is_store);
            WAIT:    stall_o = !(dmem_rsp_valid_i || timeout);
            default: stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            is_store         <= 1'b0;
            size             <= 2'd0;
            is_unsigned      <= 1'b0;
            lane             <= 2'd0;
            addr             <= 32'd0;
            rd               <= 5'd0;
            wb_en            <= 1'b0;
            count            <= 32'd0;
            dmem_req_valid_o <= 1'b0;
            dmem_req_addr_o  <= 32'd0;
            dmem_req_we_o    <= 1'b0;
            dmem_req_be_o    <= 4'd0;
            dmem_req_wdata_o <= 32'd0;
            wb_valid_o       <= 1'b0;
            wb_rd_o          <= 5'd0;
            wb_en_o          <= 1'b0;
            wb_data_o        <= 32'd0;
            bus_err_o        <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o       <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
            bus_err_o  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (valid_i && !is_mem) begin
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd_i;
                        wb_en_o    <= wb_en_i;
                        wb_data_o  <= addr_i;
                    end else if (trap) begin
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd_i;
                        wb_en_o    <= 1'b0;
                        wb_data_o  <= addr_i;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_o <= 1'b1;
`endif
                    end else if (is_mem) begin
                        is_store         <= (mem_op_i == OP_STORE);
                        size             <= mem_size_i;
                        is_unsigned      <= mem_unsigned_i;
                        lane             <= issue_lane;
                        addr             <= addr_i;
                        rd               <= rd_i;
                        wb_en            <= wb_en_i;
                        dmem_req_valid_o <= 1'b1;
                        dmem_req_addr_o  <= {addr_i[31:2], 2'b00};
                        dmem_req_we_o    <= (mem_op_i == OP_STORE);
                        dmem_req_be_o    <= issue_be;
                        dmem_req_wdata_o <= issue_wdata;
                        state            <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_req_ready_i) begin
                        dmem_req_valid_o <= 1'b0;
                        count            <= 32'd0;
                        if (is_store) begin
                            wb_valid_o <= 1'b1;
                            wb_rd_o    <= rd;
                            wb_en_o    <= 1'b0;
                            wb_data_o  <= addr;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count + 32'd1;
                    // A response arriving on the timeout cycle still completes the load.
                    if (dmem_rsp_valid_i) begin
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd;
                        wb_en_o    <= wb_en;
                        wb_data_o  <= extract(dmem_rsp_rdata_i, lane, size, is_unsigned);
                        state      <= IDLE;
                    end else if (timeout) begin
                        wb_valid_o <= 1'b1;
                        wb_rd_o    <= rd;
                        wb_en_o    <= 1'b0;
                        wb_data_o  <= addr;
                        bus_err_o  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback bundles, a monitor pops them on wb_valid_o.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [1:0]  mem_op_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [4:0]  rd_i;
    logic        wb_en_i;
    logic        stall_o;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [31:0] dmem_req_addr_o;
    logic        dmem_req_we_o;
    logic [3:0]  dmem_req_be_o;
    logic [31:0] dmem_req_wdata_o;
    logic        dmem_rsp_valid_i;
    logic [31:0] dmem_rsp_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic        wb_en_o;
    logic [31:0] wb_data_o;
    logic        bus_err_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic        en;
        logic [31:0] data;
        logic        chkData;
        logic        busErr;
        logic        mis;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    mem_stage #(.RSP_TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .mem_op_i(mem_op_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i), .rd_i(rd_i), .wb_en_i(wb_en_i), .stall_o(stall_o),
        .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
        .dmem_req_addr_o(dmem_req_addr_o), .dmem_req_we_o(dmem_req_we_o),
        .dmem_req_be_o(dmem_req_be_o), .dmem_req_wdata_o(dmem_req_wdata_o),
        .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_rdata_i(dmem_rsp_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_en_o(wb_en_o), .wb_data_o(wb_data_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pushExp(input logic [4:0] rd, input logic en, input logic [31:0] data,
                           input logic chkData, input logic busErr, input logic mis);
        exp_t e;
        e.rd = rd; e.en = en; e.data = data; e.chkData = chkData; e.busErr = busErr; e.mis = mis;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd, input logic en);
        valid_i = 1'b1; mem_op_i = op; mem_size_i = size; mem_unsigned_i = uns;
        addr_i = addr; store_data_i = data; rd_i = rd; wb_en_i = en;
    endtask

    task automatic idleInputs();
        valid_i = 1'b0; mem_op_i = 2'd0; mem_size_i = 2'd0; mem_unsigned_i = 1'b0;
        addr_i = 32'd0; store_data_i = 32'd0; rd_i = 5'd0; wb_en_i = 1'b0;
    endtask

    // Load accepted on first REQ cycle; response arrives on the gap-th WAIT cycle.
    task automatic doLoad(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic [31:0] expData, input int gap);
        applyStimulus(2'd1, size, uns, addr, 32'd0, rd, 1'b1);
        pushExp(rd, 1'b1, expData, 1'b1, 1'b0, 1'b0);
        dmem_req_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("load_issue_stall", 32'(stall_o), 32'd1);
        cyc();
        idleInputs();
        @(negedge clk_i);
        checkOutput("load_req_valid", 32'(dmem_req_valid_o), 32'd1);
        checkOutput("load_req_addr", dmem_req_addr_o, {addr[31:2], 2'b00});
        checkOutput("load_req_be", 32'(dmem_req_be_o), 32'hF);
        checkOutput("load_req_we", 32'(dmem_req_we_o), 32'd0);
        checkOutput("load_accept_stall", 32'(stall_o), 32'd1);
        cyc();
        dmem_req_ready_i = 1'b0;
        for (int i = 1; i < gap; i++) begin
            @(negedge clk_i);
            checkOutput("load_wait_stall", 32'(stall_o), 32'd1);
            cyc();
        end
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_rdata_i = rdata;
        @(negedge clk_i);
        checkOutput("load_rsp_stall", 32'(stall_o), 32'd0);
        cyc();
        dmem_rsp_valid_i = 1'b0;
        dmem_rsp_rdata_i = 32'd0;
    endtask

    task automatic doStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input logic [3:0] expBe,
                           input logic [31:0] expWdata, input int readyDelay);
        applyStimulus(2'd2, size, 1'b0, addr, data, rd, 1'b1);
        pushExp(rd, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        dmem_req_ready_i = 1'b0;
        @(negedge clk_i);
        checkOutput("store_issue_stall", 32'(stall_o), 32'd1);
        cyc();
        idleInputs();
        for (int i = 0; i <= readyDelay; i++) begin
            dmem_req_ready_i = (i == readyDelay);
            @(negedge clk_i);
            checkOutput("store_req_valid", 32'(dmem_req_valid_o), 32'd1);
            checkOutput("store_req_addr", dmem_req_addr_o, {addr[31:2], 2'b00});
            checkOutput("store_req_we", 32'(dmem_req_we_o), 32'd1);
            checkOutput("store_req_be", 32'(dmem_req_be_o), 32'(expBe));
            checkOutput("store_req_wdata", dmem_req_wdata_o, expWdata);
            checkOutput("store_stall", 32'(stall_o), (i == readyDelay) ? 32'd0 : 32'd1);
            cyc();
        end
        dmem_req_ready_i = 1'b0;
    endtask

    // Monitor: every writeback pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (wb_valid_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_wb_valid", 32'(wb_valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                    checkOutput("wb_en", 32'(wb_en_o), 32'(e.en));
                    checkOutput("wb_bus_err", 32'(bus_err_o), 32'(e.busErr));
                    if (e.chkData)
                        checkOutput("wb_data", wb_data_o, e.data);
`ifdef MEM_MISALIGN_TRAP_EN
                    checkOutput("wb_misalign", 32'(misalign_o), 32'(e.mis));
`endif
                end
            end else if (bus_err_o) begin
                checkOutput("bus_err_without_wb", 32'(bus_err_o), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        idleInputs();
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0;
        dmem_rsp_rdata_i = 32'd0;
        rst_i = 1'b1;
        repeat (2) cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_wb_valid", 32'(wb_valid_o), 32'd0);
        checkOutput("reset_req_valid", 32'(dmem_req_valid_o), 32'd0);
        checkOutput("reset_stall", 32'(stall_o), 32'd0);
        checkOutput("reset_wb_data", wb_data_o, 32'd0);
        cyc();

        // Pass-through op, then back-to-back pass-through including reserved op code.
        applyStimulus(2'd0, 2'd0, 1'b0, 32'h1234, 32'd0, 5'd5, 1'b1);
        pushExp(5'd5, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("none_stall", 32'(stall_o), 32'd0);
        cyc();
        applyStimulus(2'd3, 2'd2, 1'b0, 32'hDEAD_0001, 32'd0, 5'd6, 1'b0);
        pushExp(5'd6, 1'b0, 32'hDEAD_0001, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        checkOutput("reserved_stall", 32'(stall_o), 32'd0);
        cyc();
        idleInputs();
        repeat (2) cyc();

        doLoad(2'd0, 1'b0, 32'h0000_0103, 32'h80AB_CDEF, 5'd7, 32'hFFFF_FF80, 2);
        doLoad(2'd1, 1'b1, 32'h0000_0502, 32'h8001_7FFF, 5'd8, 32'h0000_8001, 1);
        doLoad(2'd1, 1'b0, 32'h0000_0500, 32'h1234_8765, 5'd9, 32'hFFFF_8765, 3);
        doLoad(2'd0, 1'b1, 32'h0000_0701, 32'h0000_F100, 5'd10, 32'h0000_00F1, 1);
        doLoad(2'd2, 1'b0, 32'h0000_0800, 32'hCAFE_BABE, 5'd11, 32'hCAFE_BABE, 2);

        doStore(2'd1, 32'h0000_0202, 32'h0000_BEEF, 5'd3, 4'b1100, 32'hBEEF_BEEF, 3);
        doStore(2'd0, 32'h0000_0601, 32'h1234_56A5, 5'd4, 4'b0010, 32'hA5A5_A5A5, 0);
        doStore(2'd2, 32'h0000_0604, 32'h0BAD_F00D, 5'd2, 4'b1111, 32'h0BAD_F00D, 1);
        repeat (2) cyc();

        // Response never arrives: RSP_TIMEOUT=4 WAIT cycles then a bus error pulse.
        applyStimulus(2'd1, 2'd2, 1'b0, 32'h0000_0400, 32'd0, 5'd9, 1'b1);
        pushExp(5'd9, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        dmem_req_ready_i = 1'b1;
        cyc();
        idleInputs();
        cyc();
        dmem_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput("timeout_wait_stall", 32'(stall_o), (i == 3) ? 32'd0 : 32'd1);
            cyc();
        end
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_rdata_i = 32'h5555_5555;
        cyc();
        dmem_rsp_valid_i = 1'b0;
        @(negedge clk_i);
        checkOutput("late_rsp_ignored_req", 32'(dmem_req_valid_o), 32'd0);
        checkOutput("late_rsp_ignored_stall", 32'(stall_o), 32'd0);
        cyc();

        // Reset while waiting for a response abandons the load.
        applyStimulus(2'd1, 2'd2, 1'b0, 32'h0000_0900, 32'd0, 5'd12, 1'b1);
        dmem_req_ready_i = 1'b1;
        cyc();
        idleInputs();
        cyc();
        dmem_req_ready_i = 1'b0;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_wait_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_wait_req_valid", 32'(dmem_req_valid_o), 32'd0);
        checkOutput("rst_wait_req_addr", dmem_req_addr_o, 32'd0);
        checkOutput("rst_wait_req_be", 32'(dmem_req_be_o), 32'd0);
        checkOutput("rst_wait_wb_rd", 32'(wb_rd_o), 32'd0);
        checkOutput("rst_wait_wb_data", wb_data_o, 32'd0);
        checkOutput("rst_wait_bus_err", 32'(bus_err_o), 32'd0);
        applyStimulus(2'd0, 2'd0, 1'b0, 32'h0000_CAFE, 32'd0, 5'd1, 1'b1);
        pushExp(5'd1, 1'b1, 32'h0000_CAFE, 1'b1, 1'b0, 1'b0);
        cyc();
        idleInputs();
        repeat (2) cyc();

`ifdef MEM_MISALIGN_TRAP_EN
        applyStimulus(2'd1, 2'd2, 1'b0, 32'h0000_0301, 32'd0, 5'd13, 1'b1);
        pushExp(5'd13, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_i);
        checkOutput("misalign_stall", 32'(stall_o), 32'd0);
        cyc();
        idleInputs();
        @(negedge clk_i);
        checkOutput("misalign_no_req", 32'(dmem_req_valid_o), 32'd0);
        cyc();
`else
        doLoad(2'd2, 1'b0, 32'h0000_0301, 32'h1122_3344, 5'd13, 32'h1122_3344, 1);
`endif

        repeat (3) cyc();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the execute result (ALU/MUL result used as address), store data and memory-op metadata.
- Performs loads and stores over a valid/ready data-memory request channel plus a response channel.
- Aligns and extends load data, then registers a writeback bundle for the writeback stage. Stalls upstream while an access is outstanding.

Parameters:
- RSP_TIMEOUT, 64, max cycles waiting for a load response before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  instruction from execute is valid
- addr_i  in  32  execute result; memory address for LOAD/STORE, writeback data otherwise
- store_data_i  in  32  rs2 data for stores
- mem_op_i  in  2  0=NONE, 1=LOAD, 2=STORE, 3=reserved (treated as NONE)
- mem_size_i  in  2  0=byte, 1=half, 2=word
- mem_unsigned_i  in  1  zero-extend load when 1
- rd_i  in  5  destination register
- wb_en_i  in  1  instruction writes rd
- stall_o  out  1  upstream must hold its inputs this cycle
- dmem_req_valid_o  out  1  request valid
- dmem_req_ready_i  in  1  memory accepts request
- dmem_req_addr_o  out  32  word-aligned address (bits[1:0]=0)
- dmem_req_we_o  out  1  1=store
- dmem_req_be_o  out  4  byte enables
- dmem_req_wdata_o  out  32  lane-replicated store data
- dmem_rsp_valid_i  in  1  load response valid
- dmem_rsp_rdata_i  in  32  load response word
- wb_valid_o  out  1  writeback bundle valid (one-cycle pulse per instruction)
- wb_rd_o  out  5  destination register
- wb_en_o  out  1  register write enable
- wb_data_o  out  32  writeback data
- bus_err_o  out  1  one-cycle pulse on load timeout

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0; request registers cleared. Reset mid-access abandons the request. A dmem_rsp_valid_i seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE, valid_i=0: no action; stall_o=0.
- IDLE, valid_i with op NONE or reserved:
  - Next cycle: wb_valid_o=1, wb_data_o=addr_i, wb_rd_o=rd_i, wb_en_o=wb_en_i.
  - stall_o=0. Latency is 1 cycle.
- IDLE, valid_i with LOAD/STORE:
  - Latch addr, data, size, unsigned, rd, wb_en and op.
  - Go to REQ; stall_o=1 combinationally.
  - The module samples inputs only on this IDLE cycle.
- REQ:
  - dmem_req_valid_o=1; address, we, be and wdata come from the latched registers and stay stable until ready.
  - On dmem_req_ready_i with STORE: go to IDLE; stall_o=0 this cycle; next cycle wb_valid_o=1 with wb_en_o=0.
  - On dmem_req_ready_i with LOAD: go to WAIT; stall_o stays 1.
- WAIT:
  - Counter increments each cycle.
  - On dmem_rsp_valid_i: stall_o=0; go to IDLE; next cycle wb_valid_o=1, wb_en_o=latched wb_en, wb_data_o=extracted load.
  - If RSP_TIMEOUT!=0 and counter==RSP_TIMEOUT-1 with no response: stall_o=0; go to IDLE; next cycle wb_valid_o=1, wb_en_o=0, bus_err_o=1.
  - If the response and the timeout occur in the same cycle, the response wins.
- Responses never arrive in the same cycle the request is accepted. The earliest response is the following cycle.
- Store byte enables and data:
  - Byte: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - Half: be=4'b0011<<(2*addr[1]), wdata={2{data[15:0]}}.
  - Word: be=4'b1111.
- Load extract:
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend unless unsigned; word loads pass through.
- wb_valid_o and bus_err_o are single-cycle pulses. wb_rd_o, wb_en_o and wb_data_o hold until the next pulse.
- Throughput: one non-memory instruction per cycle. Back-to-back memory ops each re-enter via IDLE.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Adds output misalign_o (1 bit).
  - A misaligned LOAD/STORE (half with addr[0]=1; word with addr[1:0]!=0) issues no request and stays in IDLE with stall_o=0.
  - Next cycle: wb_valid_o=1, wb_en_o=0, misalign_o=1 for one cycle.
- Not defined: no misalign_o port. Misaligned low address bits are ignored (half forces addr[0]=0; word forces addr[1:0]=0) and the access proceeds normally.

Test Plan:
- NONE op: addr_i=0x1234, rd=5, wb_en=1 -> next cycle wb_valid_o=1, wb_data_o=0x1234, wb_rd_o=5, stall_o never 1.
- Signed byte load: addr=0x103, ready=1 at first REQ, response 2 cycles later with rdata=0x80AB_CDEF.
  - Request carries req_addr=0x100, be=4'b1111, we=0.
  - Next cycle after response: wb_data_o=0xFFFF_FF80.
  - stall_o high from the accept cycle until the response cycle, exclusive.
- Half store: addr=0x202, data=0x0000_BEEF, ready low 3 cycles.
  - dmem_req_valid_o held 4 cycles with stable be=4'b1100, wdata=0xBEEF_BEEF.
  - Next cycle after ready: wb_valid_o=1 with wb_en_o=0.
- Timeout: RSP_TIMEOUT=4, load accepted, no response -> after 4 WAIT cycles bus_err_o=1 and wb_valid_o=1 with wb_en_o=0; a late rsp_valid in IDLE is ignored.
- Reset in WAIT: rst_i pulsed -> all outputs 0 next cycle, state IDLE; a subsequent NONE op completes normally.
- Misaligned word load at 0x301:
  - With MEM_MISALIGN_TRAP_EN: no request issued; misalign_o=1 next cycle.
  - Without it: request issued with req_addr=0x300.
